// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register sentinel and the F/D record type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        icode: I_NOP,
        ifun:  4'h0,
        ra:    REG_NONE,
        rb:    REG_NONE,
        valc:  64'd0,
        valp:  64'd0,
        stat:  STAT_AOK
    };

    function automatic logic need_regids(input logic [3:0] icode);
        return (icode == I_RRMOVQ) || (icode == I_IRMOVQ) || (icode == I_RMMOVQ) ||
               (icode == I_MRMOVQ) || (icode == I_OPQ)    || (icode == I_PUSHQ)  ||
               (icode == I_POPQ);
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        return (icode == I_IRMOVQ) || (icode == I_RMMOVQ) || (icode == I_MRMOVQ) ||
               (icode == I_JXX)    || (icode == I_CALL);
    endfunction

endpackage

// File: rtl/fetch_split.sv
// Combinational splitter: turns the 10-byte instruction window at i_pc into a decode record.
module fetch_split
    import y86_pkg::*;
(
    input  logic [63:0] i_pc,
    input  logic [79:0] i_data,
    input  logic        i_imem_error,
    output d_reg_t      o_rec
);

    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic        w_need_regids;
    logic        w_need_valc;
    logic        w_instr_valid;

    always_comb begin
        w_icode = i_data[7:4];
        w_ifun  = i_data[3:0];
        if (i_imem_error) begin
            w_icode = I_NOP;
            w_ifun  = 4'h0;
        end
    end

    assign w_need_regids = need_regids(w_icode);
    assign w_need_valc   = need_valc(w_icode);
    assign w_instr_valid = (w_icode <= I_POPQ);

    always_comb begin
        o_rec       = D_BUBBLE;
        o_rec.icode = w_icode;
        o_rec.ifun  = w_ifun;
        o_rec.ra    = w_need_regids ? i_data[15:12] : REG_NONE;
        o_rec.rb    = w_need_regids ? i_data[11:8]  : REG_NONE;
        // valC sits right after the register byte when there is one.
        if (w_need_valc) begin
            o_rec.valc = w_need_regids ? i_data[79:16] : i_data[71:8];
        end else begin
            o_rec.valc = 64'd0;
        end
        o_rec.valp = i_pc + 64'd1 + {63'd0, w_need_regids} + (w_need_valc ? 64'd8 : 64'd0);
        if (i_imem_error) begin
            o_rec.stat = STAT_ADR;
        end else if (!w_instr_valid) begin
            o_rec.stat = STAT_INS;
        end else if (w_icode == I_HALT) begin
            o_rec.stat = STAT_HLT;
        end else begin
            o_rec.stat = STAT_AOK;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage with PC selection, prediction, sticky halt and the F/D register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [63:0] imem_addr_o,
    input  logic [79:0] imem_data_i,
    input  logic        imem_error_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    input  logic        F_stall_i,
    input  logic        D_stall_i,
    input  logic        D_bubble_i,
    output logic [3:0]  D_icode_o,
    output logic [3:0]  D_ifun_o,
    output logic [3:0]  D_rA_o,
    output logic [3:0]  D_rB_o,
    output logic [63:0] D_valC_o,
    output logic [63:0] D_valP_o,
    output logic [2:0]  D_stat_o,
    output logic        f_halted_o,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_bubble_o
);

    logic [63:0] r_pred_pc;
    d_reg_t      r_d;
    logic        r_halted;

    logic        w_mispredict;
    logic        w_ret;
    logic        w_redirect;
    logic [63:0] w_f_pc;
    d_reg_t      w_rec;
    logic [63:0] w_prediction;
    logic        w_fetch_en;
    logic        w_d_load;

    assign w_mispredict = (M_icode_i == I_JXX) && !M_cnd_i;
    assign w_ret        = (W_icode_i == I_RET);
    assign w_redirect   = w_mispredict || w_ret;
    assign w_f_pc       = w_mispredict ? M_valA_i : (w_ret ? W_valM_i : r_pred_pc);

    fetch_split u_split (
        .i_pc         (w_f_pc),
        .i_data       (imem_data_i),
        .i_imem_error (imem_error_i),
        .o_rec        (w_rec)
    );

    assign w_prediction = ((w_rec.icode == I_JXX) || (w_rec.icode == I_CALL)) ?
                          w_rec.valc : w_rec.valp;
    // A redirect restarts fetch even while halted.
    assign w_fetch_en   = !r_halted || w_redirect;
    assign w_d_load     = !D_stall_i && !D_bubble_i && w_fetch_en;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pred_pc <= RESET_PC;
        end else if (!F_stall_i && w_fetch_en) begin
            r_pred_pc <= w_prediction;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_d <= D_BUBBLE;
        end else if (!D_stall_i) begin
            r_d <= w_d_load ? w_rec : D_BUBBLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_halted <= 1'b0;
        end else if (w_d_load && (w_rec.stat != STAT_AOK)) begin
            r_halted <= 1'b1;
        end else if (w_redirect) begin
            r_halted <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;
    logic        w_d_bubble;

    assign w_d_bubble = !D_stall_i && !w_d_load;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_perf_fetch  <= 32'd0;
            r_perf_bubble <= 32'd0;
        end else begin
            if (w_d_load && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_d_bubble && (r_perf_bubble != 32'hFFFF_FFFF)) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetch_o  = r_perf_fetch;
    assign perf_bubble_o = r_perf_bubble;
`else
    assign perf_fetch_o  = 32'd0;
    assign perf_bubble_o = 32'd0;
`endif

    assign imem_addr_o = w_f_pc;
    assign D_icode_o   = r_d.icode;
    assign D_ifun_o    = r_d.ifun;
    assign D_rA_o      = r_d.ra;
    assign D_rB_o      = r_d.rb;
    assign D_valC_o    = r_d.valc;
    assign D_valP_o    = r_d.valp;
    assign D_stat_o    = r_d.stat;
    assign f_halted_o  = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; perf expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [2:0]  D_stat;
    logic        f_halted;
    logic [31:0] perf_fetch, perf_bubble;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [79:0] W_IRMOVQ = 80'h0008_F230; // irmovq $8,%rdx
    localparam logic [79:0] W_NOP    = 80'h10;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .imem_error_i  (imem_error),
        .M_icode_i     (M_icode),
        .M_cnd_i       (M_cnd),
        .M_valA_i      (M_valA),
        .W_icode_i     (W_icode),
        .W_valM_i      (W_valM),
        .F_stall_i     (F_stall),
        .D_stall_i     (D_stall),
        .D_bubble_i    (D_bubble),
        .D_icode_o     (D_icode),
        .D_ifun_o      (D_ifun),
        .D_rA_o        (D_rA),
        .D_rB_o        (D_rB),
        .D_valC_o      (D_valC),
        .D_valP_o      (D_valP),
        .D_stat_o      (D_stat),
        .f_halted_o    (f_halted),
        .perf_fetch_o  (perf_fetch),
        .perf_bubble_o (perf_bubble)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_data = W_NOP; imem_error = 1'b0;
        M_icode = 4'h0; M_cnd = 1'b0; M_valA = 64'd0; W_icode = 4'h0; W_valM = 64'd0;
        F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        #12;
        n_vec++; if (D_icode !== 4'h1) begin $display("FAIL reset_icode got %h want 1", D_icode); n_err++; end
        n_vec++; if (D_rA !== 4'hF || D_rB !== 4'hF) begin $display("FAIL reset_regs got %h/%h want F/F", D_rA, D_rB); n_err++; end
        n_vec++; if (D_valC !== 64'd0 || D_valP !== 64'd0) begin $display("FAIL reset_vals got %h/%h want 0/0", D_valC, D_valP); n_err++; end
        n_vec++; if (D_stat !== 3'd1) begin $display("FAIL reset_stat got %0d want 1", D_stat); n_err++; end
        n_vec++; if (f_halted !== 1'b0) begin $display("FAIL reset_halt got %b want 0", f_halted); n_err++; end
        n_vec++; if (imem_addr !== 64'd0) begin $display("FAIL reset_addr got %h want 0", imem_addr); n_err++; end
        n_vec++; if (perf_fetch !== 32'd0 || perf_bubble !== 32'd0) begin $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetch, perf_bubble); n_err++; end
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_irmovq();
        imem_data = W_IRMOVQ;
        #1;
        n_vec++; if (imem_addr !== 64'd0) begin $display("FAIL irmov_addr got %h want 0", imem_addr); n_err++; end
        step();
        n_vec++; if (D_icode !== 4'h3 || D_ifun !== 4'h0) begin $display("FAIL irmov_code got %h%h want 30", D_icode, D_ifun); n_err++; end
        n_vec++; if (D_rA !== 4'hF || D_rB !== 4'h2) begin $display("FAIL irmov_regs got %h/%h want F/2", D_rA, D_rB); n_err++; end
        n_vec++; if (D_valC !== 64'd8 || D_valP !== 64'd10) begin $display("FAIL irmov_vals got %h/%h want 8/a", D_valC, D_valP); n_err++; end
        n_vec++; if (D_stat !== 3'd1) begin $display("FAIL irmov_stat got %0d want 1", D_stat); n_err++; end
        n_vec++; if (imem_addr !== 64'd10) begin $display("FAIL irmov_pred got %h want a", imem_addr); n_err++; end
    endtask

    task automatic test_jxx();
        imem_data = 80'h2070; // jmp 0x20 at 0xa
        step();
        n_vec++; if (D_icode !== 4'h7 || D_valC !== 64'h20 || D_valP !== 64'h13) begin $display("FAIL jmp_fields got %h/%h/%h want 7/20/13", D_icode, D_valC, D_valP); n_err++; end
        n_vec++; if (imem_addr !== 64'h20) begin $display("FAIL jmp_pred got %h want 20", imem_addr); n_err++; end
        imem_data = 80'h01_0074; // jne 0x100 at 0x20
        step();
        n_vec++; if (D_ifun !== 4'h4 || D_valC !== 64'h100 || D_valP !== 64'h29) begin $display("FAIL jne_fields got %h/%h/%h want 4/100/29", D_ifun, D_valC, D_valP); n_err++; end
        n_vec++; if (imem_addr !== 64'h100) begin $display("FAIL jne_pred got %h want 100", imem_addr); n_err++; end
    endtask

    task automatic test_redirect();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h29;
        #1;
        n_vec++; if (imem_addr !== 64'h29) begin $display("FAIL mispredict_addr got %h want 29", imem_addr); n_err++; end
        W_icode = 4'h9; W_valM = 64'h500;
        #1;
        n_vec++; if (imem_addr !== 64'h29) begin $display("FAIL mispredict_over_ret got %h want 29", imem_addr); n_err++; end
        M_cnd = 1'b1;
        #1;
        n_vec++; if (imem_addr !== 64'h500) begin $display("FAIL taken_then_ret got %h want 500", imem_addr); n_err++; end
        M_icode = 4'h0; M_cnd = 1'b0; W_icode = 4'h0;
        #1;
        n_vec++; if (imem_addr !== 64'h100) begin $display("FAIL redirect_release got %h want 100", imem_addr); n_err++; end
    endtask

    task automatic test_invalid();
        imem_data = 80'hF0;
        step();
        n_vec++; if (D_stat !== 3'd4 || D_icode !== 4'hF) begin $display("FAIL ins_stat got %0d/%h want 4/f", D_stat, D_icode); n_err++; end
        n_vec++; if (f_halted !== 1'b1) begin $display("FAIL ins_halt got %b want 1", f_halted); n_err++; end
        n_vec++; if (imem_addr !== 64'h101) begin $display("FAIL ins_pred got %h want 101", imem_addr); n_err++; end
        imem_data = W_IRMOVQ;
        step();
        n_vec++; if (D_icode !== 4'h1 || D_valP !== 64'd0 || D_stat !== 3'd1) begin $display("FAIL halted_bubble got %h/%h/%0d want 1/0/1", D_icode, D_valP, D_stat); n_err++; end
        n_vec++; if (imem_addr !== 64'h101 || f_halted !== 1'b1) begin $display("FAIL halted_frozen got %h/%b want 101/1", imem_addr, f_halted); n_err++; end
        W_icode = 4'h9; W_valM = 64'h40; imem_data = W_NOP;
        #1;
        n_vec++; if (imem_addr !== 64'h40) begin $display("FAIL ret_resume_addr got %h want 40", imem_addr); n_err++; end
        step();
        W_icode = 4'h0;
        #1;
        n_vec++; if (D_icode !== 4'h1 || D_valP !== 64'h41) begin $display("FAIL ret_resume_d got %h/%h want 1/41", D_icode, D_valP); n_err++; end
        n_vec++; if (f_halted !== 1'b0 || imem_addr !== 64'h41) begin $display("FAIL ret_resume_state got %b/%h want 0/41", f_halted, imem_addr); n_err++; end
    endtask

    task automatic test_imem_error();
        imem_error = 1'b1; imem_data = W_IRMOVQ;
        step();
        imem_error = 1'b0;
        #1;
        n_vec++; if (D_icode !== 4'h1 || D_ifun !== 4'h0 || D_stat !== 3'd3) begin $display("FAIL adr_fields got %h/%h/%0d want 1/0/3", D_icode, D_ifun, D_stat); n_err++; end
        n_vec++; if (D_valP !== 64'h42 || f_halted !== 1'b1) begin $display("FAIL adr_valp got %h/%b want 42/1", D_valP, f_halted); n_err++; end
        D_stall = 1'b1; D_bubble = 1'b1;
        step();
        n_vec++; if (D_icode !== 4'h1 || D_stat !== 3'd3 || D_valP !== 64'h42) begin $display("FAIL stall_hold got %h/%0d/%h want 1/3/42", D_icode, D_stat, D_valP); n_err++; end
        D_stall = 1'b0; D_bubble = 1'b0;
    endtask

    task automatic test_load_use();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h60; imem_data = W_IRMOVQ;
        step();
        M_icode = 4'h0;
        #1;
        n_vec++; if (D_icode !== 4'h3 || D_valP !== 64'h6A || f_halted !== 1'b0) begin $display("FAIL mp_resume got %h/%h/%b want 3/6a/0", D_icode, D_valP, f_halted); n_err++; end
        F_stall = 1'b1; D_bubble = 1'b1; imem_data = W_NOP;
        step();
        n_vec++; if (D_icode !== 4'h1 || D_valP !== 64'd0) begin $display("FAIL loaduse_bubble got %h/%h want 1/0", D_icode, D_valP); n_err++; end
        n_vec++; if (imem_addr !== 64'h6A) begin $display("FAIL loaduse_hold got %h want 6a", imem_addr); n_err++; end
        F_stall = 1'b0; D_bubble = 1'b0;
    endtask

    task automatic test_perf();
        logic [31:0] exp_fetch;
        logic [31:0] exp_bubble;
`ifdef FETCH_PERF_CNT_EN
        exp_fetch = 32'd5; exp_bubble = 32'd2;
`else
        exp_fetch = 32'd0; exp_bubble = 32'd0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (imem_addr !== 64'd0 || f_halted !== 1'b0) begin $display("FAIL midreset_state got %h/%b want 0/0", imem_addr, f_halted); n_err++; end
        n_vec++; if (perf_fetch !== 32'd0 || perf_bubble !== 32'd0) begin $display("FAIL midreset_perf got %0d/%0d want 0/0", perf_fetch, perf_bubble); n_err++; end
        step();
        rst_n = 1'b1; imem_data = W_NOP;
        for (int i = 0; i < 5; i++) step();
        D_bubble = 1'b1;
        for (int i = 0; i < 2; i++) step();
        D_bubble = 1'b0;
        n_vec++; if (imem_addr !== 64'd7) begin $display("FAIL perf_addr got %h want 7", imem_addr); n_err++; end
        n_vec++; if (perf_fetch !== exp_fetch) begin $display("FAIL perf_fetch got %0d want %0d", perf_fetch, exp_fetch); n_err++; end
        n_vec++; if (perf_bubble !== exp_bubble) begin $display("FAIL perf_bubble got %0d want %0d", perf_bubble, exp_bubble); n_err++; end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_jxx();
        test_redirect();
        test_invalid();
        test_imem_error();
        test_load_use();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
